// File: rtl/id_ex_stage.sv
// ID/EX issue register: MIPS ALU decode, immediate select, operand forwarding,
// one-entry valid/ready holding stage in front of the execute ALU.
module id_ex_stage #(
  parameter int W    = 32,
  parameter int RIDX = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic [15:0]     imm16,
  input  logic [RIDX-1:0] rs_idx,
  input  logic [RIDX-1:0] rt_idx,
  input  logic [RIDX-1:0] rd_idx,
  input  logic [W-1:0]    rs_val,
  input  logic [W-1:0]    rt_val,
  input  logic            exmem_wen,
  input  logic [RIDX-1:0] exmem_idx,
  input  logic [W-1:0]    exmem_val,
  input  logic            memwb_wen,
  input  logic [RIDX-1:0] memwb_idx,
  input  logic [W-1:0]    memwb_val,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic [3:0]      alu_ctrl,
  output logic [RIDX-1:0] dst_idx,
  output logic            dst_wen,
  output logic            ovf_trap_en,
  output logic            illegal
);

  logic            valid_q;
  logic [W-1:0]    a_q, b_q;
  logic [3:0]      ctrl_q;
  logic [RIDX-1:0] dst_q;
  logic            wen_q, ovf_q, ill_q;

  logic [W-1:0]    a_d, b_d, imm_ext;
  logic [3:0]      ctrl_d;
  logic [RIDX-1:0] dst_d;
  logic            wen_d, ovf_d, ill_d;
  logic            use_imm, sext;
  logic            cap;

  function automatic logic [W-1:0] fwd(
    input logic [RIDX-1:0] idx,
    input logic [W-1:0]    rf,
    input logic            xw,
    input logic [RIDX-1:0] xi,
    input logic [W-1:0]    xv,
    input logic            mw,
    input logic [RIDX-1:0] mi,
    input logic [W-1:0]    mv
  );
    logic [W-1:0] r;
    r = rf;
    if (idx != '0 && xw && xi == idx)
      r = xv;
    else if (idx != '0 && mw && mi == idx)
      r = mv;
    return r;
  endfunction

  always_comb begin
    ctrl_d  = 4'b1111;
    ill_d   = 1'b1;
    ovf_d   = 1'b0;
    use_imm = 1'b0;
    sext    = 1'b0;
    unique case (opcode)
      6'h00: begin
        ill_d = 1'b0;
        unique case (funct)
          6'h21:   ctrl_d = 4'b0000;
          6'h20: begin
            ctrl_d = 4'b0001;
            ovf_d  = 1'b1;
          end
          6'h24:   ctrl_d = 4'b0010;
          6'h25:   ctrl_d = 4'b0011;
          6'h27:   ctrl_d = 4'b0101;
          6'h26:   ctrl_d = 4'b0110;
          6'h23:   ctrl_d = 4'b1000;
          6'h22: begin
            ctrl_d = 4'b1001;
            ovf_d  = 1'b1;
          end
          6'h2B:   ctrl_d = 4'b1010;
          6'h2A:   ctrl_d = 4'b1011;
          default: ill_d  = 1'b1;
        endcase
      end
      6'h08: begin
        {ill_d, use_imm, sext} = 3'b011;
        ctrl_d = 4'b0001;
        ovf_d  = 1'b1;
      end
      6'h09: begin
        {ill_d, use_imm, sext} = 3'b011;
        ctrl_d = 4'b0000;
      end
      6'h0C: begin
        {ill_d, use_imm, sext} = 3'b010;
        ctrl_d = 4'b0010;
      end
      6'h0D: begin
        {ill_d, use_imm, sext} = 3'b010;
        ctrl_d = 4'b0011;
      end
      6'h0E: begin
        {ill_d, use_imm, sext} = 3'b010;
        ctrl_d = 4'b0110;
      end
      6'h0A: begin
        {ill_d, use_imm, sext} = 3'b011;
        ctrl_d = 4'b1011;
      end
      6'h0B: begin
        {ill_d, use_imm, sext} = 3'b011;
        ctrl_d = 4'b1010;
      end
      default: ;
    endcase
    // an unlisted R-type funct must not leave a partial decode behind
    if (ill_d) begin
      ctrl_d = 4'b1111;
      ovf_d  = 1'b0;
    end
  end

  always_comb begin
    imm_ext = sext ? {{(W-16){imm16[15]}}, imm16}
                   : {{(W-16){1'b0}}, imm16};
    a_d = fwd(rs_idx, rs_val,
              exmem_wen, exmem_idx, exmem_val,
              memwb_wen, memwb_idx, memwb_val);
    b_d = use_imm ? imm_ext
                  : fwd(rt_idx, rt_val,
                        exmem_wen, exmem_idx, exmem_val,
                        memwb_wen, memwb_idx, memwb_val);
    dst_d = use_imm ? rt_idx : rd_idx;
    wen_d = !ill_d && (dst_d != '0);
  end

  assign in_ready = !valid_q || out_ready;
  assign cap      = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      dst_q   <= '0;
      wen_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else if (cap) begin
      valid_q <= 1'b1;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      dst_q   <= dst_d;
      wen_q   <= wen_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end else if (flush || out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_ctrl    = ctrl_q;
  assign dst_idx     = dst_q;
  assign dst_wen     = wen_q;
  assign ovf_trap_en = ovf_q;
  assign illegal     = ill_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed decode, immediate,
// forwarding, stall, flush, illegal and async reset vectors.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  opcode = '0, funct = '0;
  logic [15:0] imm16 = '0;
  logic [4:0]  rs_idx = '0, rt_idx = '0, rd_idx = '0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        exmem_wen = 1'b0, memwb_wen = 1'b0;
  logic [4:0]  exmem_idx = '0, memwb_idx = '0;
  logic [31:0] exmem_val = '0, memwb_val = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic [4:0]  dst_idx;
  logic        dst_wen, ovf_trap_en, illegal;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic [4:0]  d;
    logic        w;
    logic        o;
    logic        i;
  } exp_t;

  exp_t sb[$];

  id_ex_stage #(.W(32), .RIDX(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .imm16(imm16),
    .rs_idx(rs_idx), .rt_idx(rt_idx), .rd_idx(rd_idx),
    .rs_val(rs_val), .rt_val(rt_val),
    .exmem_wen(exmem_wen), .exmem_idx(exmem_idx), .exmem_val(exmem_val),
    .memwb_wen(memwb_wen), .memwb_idx(memwb_idx), .memwb_val(memwb_val),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .dst_idx(dst_idx), .dst_wen(dst_wen),
    .ovf_trap_en(ovf_trap_en), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic [31:0] a, b, input logic [3:0] c,
    input logic [4:0] d, input logic w, o, i);
    exp_t e;
    e.a = a; e.b = b; e.c = c; e.d = d;
    e.w = w; e.o = o; e.i = i;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pop and compare on every accepted output beat
  int item = 0;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      exp_t e;
      logic ok;
      checks++;
      item++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL item%0d: unexpected output ctrl=%h a=%h",
                 item, alu_ctrl, alu_a);
      end else begin
        e = sb.pop_front();
        ok = (alu_a === e.a) && (alu_b === e.b) && (alu_ctrl === e.c) &&
             (dst_wen === e.w) && (ovf_trap_en === e.o) &&
             (illegal === e.i) && (e.i || dst_idx === e.d);
        if (!ok) begin
          failures++;
          $display("FAIL item%0d: got a=%h b=%h c=%h d=%0d w=%b o=%b i=%b exp a=%h b=%h c=%h d=%0d w=%b o=%b i=%b",
                   item, alu_a, alu_b, alu_ctrl, dst_idx, dst_wen,
                   ovf_trap_en, illegal, e.a, e.b, e.c, e.d, e.w, e.o, e.i);
        end
      end
    end
  end

  task automatic drive(input logic [5:0] op, fn, input logic [15:0] imm,
                       input logic [4:0] rs, rt, rd,
                       input logic [31:0] rsv, rtv);
    opcode = op; funct = fn; imm16 = imm;
    rs_idx = rs; rt_idx = rt; rd_idx = rd;
    rs_val = rsv; rt_val = rtv;
    in_valid = 1'b1;
  endtask

  // called just after a rising edge; returns just after the accepting edge
  task automatic issue(input logic [5:0] op, fn, input logic [15:0] imm,
                       input logic [4:0] rs, rt, rd,
                       input logic [31:0] rsv, rtv,
                       input exp_t e, input bit push);
    bit acc;
    drive(op, fn, imm, rs, rt, rd, rsv, rtv);
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk);
    end
    if (acc && push) sb.push_back(e);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept: timeout got in_ready=%b expected 1", in_ready);
    end
    #1 in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_flags", {24'b0, alu_ctrl, dst_wen, ovf_trap_en, illegal, |dst_idx},
        32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    issue(6'h00, 6'h20, 16'h0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7,
          mk(32'd5, 32'd7, 4'b0001, 5'd3, 1, 1, 0), 1);
    issue(6'h09, 6'h00, 16'hFFFF, 5'd1, 5'd4, 5'd0, 32'd10, 32'd0,
          mk(32'd10, 32'hFFFFFFFF, 4'b0000, 5'd4, 1, 0, 0), 1);
    issue(6'h0D, 6'h00, 16'hFFFF, 5'd1, 5'd5, 5'd0, 32'h12340000, 32'd0,
          mk(32'h12340000, 32'h0000FFFF, 4'b0011, 5'd5, 1, 0, 0), 1);
    issue(6'h0A, 6'h00, 16'h8000, 5'd1, 5'd6, 5'd0, 32'd3, 32'd0,
          mk(32'd3, 32'hFFFF8000, 4'b1011, 5'd6, 1, 0, 0), 1);
    issue(6'h0C, 6'h00, 16'h8001, 5'd1, 5'd7, 5'd0, 32'd1, 32'd0,
          mk(32'd1, 32'h00008001, 4'b0010, 5'd7, 1, 0, 0), 1);
    issue(6'h0E, 6'h00, 16'hF00F, 5'd1, 5'd7, 5'd0, 32'd1, 32'd0,
          mk(32'd1, 32'h0000F00F, 4'b0110, 5'd7, 1, 0, 0), 1);
    issue(6'h0B, 6'h00, 16'hFFFE, 5'd1, 5'd7, 5'd0, 32'd1, 32'd0,
          mk(32'd1, 32'hFFFFFFFE, 4'b1010, 5'd7, 1, 0, 0), 1);
    issue(6'h00, 6'h22, 16'h0, 5'd1, 5'd2, 5'd9, 32'd9, 32'd4,
          mk(32'd9, 32'd4, 4'b1001, 5'd9, 1, 1, 0), 1);
    issue(6'h00, 6'h2B, 16'h0, 5'd1, 5'd2, 5'd9, 32'd9, 32'd4,
          mk(32'd9, 32'd4, 4'b1010, 5'd9, 1, 0, 0), 1);
    issue(6'h00, 6'h27, 16'h0, 5'd1, 5'd2, 5'd9, 32'd9, 32'd4,
          mk(32'd9, 32'd4, 4'b0101, 5'd9, 1, 0, 0), 1);
    issue(6'h00, 6'h23, 16'h0, 5'd1, 5'd2, 5'd9, 32'd9, 32'd4,
          mk(32'd9, 32'd4, 4'b1000, 5'd9, 1, 0, 0), 1);
    issue(6'h00, 6'h2A, 16'h0, 5'd1, 5'd2, 5'd9, 32'd9, 32'd4,
          mk(32'd9, 32'd4, 4'b1011, 5'd9, 1, 0, 0), 1);

    exmem_wen = 1; exmem_idx = 5'd2; exmem_val = 32'hAAAA;
    memwb_wen = 1; memwb_idx = 5'd2; memwb_val = 32'hBBBB;
    issue(6'h00, 6'h24, 16'h0, 5'd2, 5'd2, 5'd7, 32'd1, 32'd1,
          mk(32'hAAAA, 32'hAAAA, 4'b0010, 5'd7, 1, 0, 0), 1);
    issue(6'h08, 6'h00, 16'h0010, 5'd2, 5'd2, 5'd0, 32'd1, 32'd1,
          mk(32'hAAAA, 32'h10, 4'b0001, 5'd2, 1, 1, 0), 1);
    exmem_wen = 0;
    issue(6'h00, 6'h25, 16'h0, 5'd2, 5'd2, 5'd7, 32'd1, 32'd1,
          mk(32'hBBBB, 32'hBBBB, 4'b0011, 5'd7, 1, 0, 0), 1);
    memwb_wen = 0;
    exmem_wen = 1; exmem_idx = 5'd0; exmem_val = 32'hDEAD;
    issue(6'h00, 6'h21, 16'h0, 5'd0, 5'd3, 5'd8, 32'h11, 32'h22,
          mk(32'h11, 32'h22, 4'b0000, 5'd8, 1, 0, 0), 1);
    exmem_wen = 0;

    issue(6'h3F, 6'h20, 16'h0, 5'd1, 5'd9, 5'd9, 32'd1, 32'd2,
          mk(32'd1, 32'd2, 4'b1111, 5'd0, 0, 0, 1), 1);
    issue(6'h00, 6'h00, 16'h0, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2,
          mk(32'd1, 32'd2, 4'b1111, 5'd0, 0, 0, 1), 1);
    issue(6'h00, 6'h21, 16'h0, 5'd1, 5'd2, 5'd0, 32'd1, 32'd2,
          mk(32'd1, 32'd2, 4'b0000, 5'd0, 0, 0, 0), 1);

    // stall: hold sub, offer xor that must not enter
    issue(6'h00, 6'h22, 16'h0, 5'd1, 5'd2, 5'd10, 32'd100, 32'd30,
          mk(32'd100, 32'd30, 4'b1001, 5'd10, 1, 1, 0), 1);
    out_ready = 1'b0;
    drive(6'h00, 6'h26, 16'h0, 5'd3, 5'd4, 5'd11, 32'd55, 32'd66);
    for (int n = 0; n < 2; n++) begin
      @(posedge clk); #2;
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_a", alu_a, 32'd100);
      chk("stall_b", alu_b, 32'd30);
      chk("stall_ctrl", {28'b0, alu_ctrl}, 32'd9);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // flush drops an acceptable incoming instruction
    drive(6'h00, 6'h21, 16'h0, 5'd1, 5'd2, 5'd12, 32'd7, 32'd7);
    flush = 1'b1;
    #1 chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("flush_valid2", {31'b0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("sb_drained", sb.size(), 32'd0);

    // async reset mid-cycle while holding a valid instruction
    out_ready = 1'b0;
    issue(6'h00, 6'h20, 16'h0, 5'd1, 5'd2, 5'd3, 32'd8, 32'd9,
          mk(32'd0, 32'd0, 4'd0, 5'd0, 0, 0, 0), 0);
    #1 chk("hold_valid", {31'b0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_a", alu_a, 32'd0);
    chk("arst_flags", {24'b0, alu_ctrl, dst_wen, ovf_trap_en, illegal, |dst_idx},
        32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
